spmv_stream_fifo: RTL and testbench
===================================

# spmv_stream_fifo

Parametrised first-word-fall-through (show-ahead) FIFO with valid/ready handshakes on both sides, occupancy count, programmable almost-full/almost-empty thresholds, synchronous flush and a sticky overflow flag. It is the next-generation buffer between SpMV pipeline stages, for example between the CSR value/column fetch and the multiply-accumulate lane. It supports any depth ≥ 2, not only powers of two, and a zero-wait read path: head data is visible before it is popped.

## Interface
- DATA_WIDTH, 32, bits per entry
- FIFO_DEPTH, 16, number of entries, ≥ 2, any integer
- ADDR_WIDTH, $clog2(FIFO_DEPTH), pointer width (derived; do not override)
- AFULL_THRESH, FIFO_DEPTH-2, almost_full asserted when count ≥ this value
- AEMPTY_THRESH, 2, almost_empty asserted when count ≤ this value

- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- flush  input  1  synchronous clear of contents
- in_valid  input  1  producer has data
- in_ready  output  1  FIFO accepts data (= !full)
- in_data  input  DATA_WIDTH  write data
- out_valid  output  1  head entry valid (= !empty)
- out_ready  input  1  consumer takes head
- out_data  output  DATA_WIDTH  head entry; 0 when out_valid=0
- count  output  ADDR_WIDTH+1  current occupancy, 0..FIFO_DEPTH
- almost_full  output  1  count ≥ AFULL_THRESH
- almost_empty  output  1  count ≤ AEMPTY_THRESH
- overflow  output  1  sticky: in_valid seen while in_ready=0

## Operation
- Storage: FIFO_DEPTH × DATA_WIDTH register array. The array is not reset. Separate rd_ptr and wr_ptr, each ADDR_WIDTH bits, plus a count register.
- push = in_valid & in_ready. pop = out_valid & out_ready.
- On push, write mem[wr_ptr] and advance wr_ptr. On pop, advance rd_ptr.
- Pointer advance: if ptr == FIFO_DEPTH-1, next value is 0; otherwise ptr+1. No modulo on a non-power-of-two depth.
- Count update: push only → +1; pop only → −1; both or neither → unchanged. There is a single count driver; it must not be split across processes.
- in_ready = (count != FIFO_DEPTH). A pop in the same cycle does not make a full FIFO ready; there is no full-bypass path.
- out_valid = (count != 0). out_data = mem[rd_ptr] combinationally when out_valid=1, otherwise 0.
- Empty FIFO: a push does not appear on out_data in the same cycle; there is no empty-bypass path.
- almost_full, almost_empty and in_ready/out_valid are combinational functions of count only.
- overflow: set on any cycle with in_valid=1 and in_ready=0. It holds until rst or flush. A rejected word is not stored and the producer must hold it, so overflow signals a protocol-monitor condition, not data loss by the FIFO.
- flush=1: on the next edge, pointers, count and overflow go to 0. Any push or pop in the same cycle is ignored; flush has priority.
- rst asserted at any time: state clears immediately without waiting for clk, and any in-flight handshake is discarded.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, count=0, almost_full=0 (for AFULL_THRESH ≥ 1), almost_empty=1, overflow=0.
- Write-to-read latency is 1 cycle. A word pushed at edge N gives out_valid=1 with that word on out_data after edge N.
- Pop takes effect at the edge. The next head, or out_valid=0, is visible after that edge.
- Full throughput: a simultaneous push and pop every cycle is sustained at any 0 < count < FIFO_DEPTH.
- The count, flag and handshake outputs all update in the same cycle after the edge.
- After rst deasserts, the first push is accepted at the first rising edge.

## Test plan
- Reset/idle: assert rst mid-cycle while count=3 → immediately count=0, out_valid=0, out_data=0, in_ready=1, almost_empty=1.
- Fill/drain, DEPTH=5, out_ready=0: push 1..5 → count 5, in_ready=0, almost_full=1 from count 3. Keep in_valid=1 with data 6 → overflow=1 and count stays 5. Then out_ready=1 → outputs 1,2,3,4,5 in order, no 6, out_valid=0 after the 5th pop.
- Wrap-around, DEPTH=5: 12 push/pop pairs at count=2 steady state → data in order, count constant at 2, pointers wrap 4→0 with no gaps.
- Full plus simultaneous pop: count=FIFO_DEPTH, in_valid=1, out_ready=1 → pop accepted, push rejected. Count becomes DEPTH−1, in_ready rises next cycle, overflow=1.
- Flush priority: count=4 with push and pop asserted together with flush → next cycle count=0, out_valid=0, overflow=0. A subsequent push of 0xA5 appears one cycle later as the head.
- Random valid/ready (10k cycles, DEPTH=7) against a scoreboard → no loss, no duplication, order preserved, and count equals the model every cycle.

Source files
------------

// File: rtl/spmv_stream_fifo_if.sv
// Valid/ready stream bundle used on both sides of the SpMV stream FIFO.
// master drives valid/data and observes ready; slave does the reverse.
interface spmv_stream_fifo_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;

  modport master (output valid, output data, input  ready);
  modport slave  (input  valid, input  data, output ready);
endinterface

// File: rtl/spmv_stream_fifo.sv
// Show-ahead FIFO between SpMV pipeline stages. Any depth >= 2; pointers
// wrap explicitly at FIFO_DEPTH-1 so non-power-of-two depths need no modulo.
// The head entry is visible on out_if.data before it is popped.
module spmv_stream_fifo #(
  parameter int DATA_WIDTH    = 32,
  parameter int FIFO_DEPTH    = 16,
  parameter int ADDR_WIDTH    = $clog2(FIFO_DEPTH),
  parameter int AFULL_THRESH  = FIFO_DEPTH - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  spmv_stream_fifo_if.slave     in_if,
  spmv_stream_fifo_if.master    out_if,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_CNT  = (ADDR_WIDTH+1)'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH:0]   AFULL_CNT  = (ADDR_WIDTH+1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0]   AEMPTY_CNT = (ADDR_WIDTH+1)'(AEMPTY_THRESH);
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR   = ADDR_WIDTH'(FIFO_DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;

  function automatic logic [ADDR_WIDTH-1:0] next_ptr(input logic [ADDR_WIDTH-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Handshakes and flags derive from count alone; a pop never frees a slot
  // for a same-cycle push, and a push never reaches out_data in the same cycle.
  assign full         = (count == DEPTH_CNT);
  assign empty        = (count == '0);
  assign in_if.ready  = !full;
  assign out_if.valid = !empty;
  assign push         = in_if.valid & !full;
  assign pop          = !empty & out_if.ready;
  assign out_if.data  = empty ? '0 : mem[rd_ptr];
  assign almost_full  = (count >= AFULL_CNT);
  assign almost_empty = (count <= AEMPTY_CNT);

  // Storage array: written on an accepted push, deliberately not reset.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= in_if.data;
    end
  end

  // Pointers, occupancy and sticky overflow; flush overrides any handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (in_if.valid && full) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spmv_stream_fifo.sv
// Directed bench for spmv_stream_fifo: a DEPTH=5 instance for the directed
// scenarios and a DEPTH=7 instance for random traffic against a queue model.
module tb_spmv_stream_fifo;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush5 = 1'b0;
  logic flush7 = 1'b0;

  logic [3:0] c5, c7;
  logic af5, ae5, ov5;
  logic af7, ae7, ov7;

  int passed = 0;
  int total  = 0;

  spmv_stream_fifo_if #(.DATA_WIDTH(32)) in5  ();
  spmv_stream_fifo_if #(.DATA_WIDTH(32)) out5 ();
  spmv_stream_fifo_if #(.DATA_WIDTH(32)) in7  ();
  spmv_stream_fifo_if #(.DATA_WIDTH(32)) out7 ();

  spmv_stream_fifo #(.DATA_WIDTH(32), .FIFO_DEPTH(5)) u5 (
    .clk(clk), .rst(rst), .flush(flush5),
    .in_if(in5.slave), .out_if(out5.master),
    .count(c5), .almost_full(af5), .almost_empty(ae5), .overflow(ov5)
  );

  spmv_stream_fifo #(.DATA_WIDTH(32), .FIFO_DEPTH(7)) u7 (
    .clk(clk), .rst(rst), .flush(flush7),
    .in_if(in7.slave), .out_if(out7.master),
    .count(c7), .almost_full(af7), .almost_empty(ae7), .overflow(ov7)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    in5.valid = 1'b1;
    out5.ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in5.data = 32'(i + 1);
      tick();
    end
    in5.valid = 1'b0;
    total++; if (c5 !== 4'd3) $display("FAIL reset_precount act=%0d exp=3", c5); else passed++;
    #2 rst = 1'b1;
    #1;
    total++; if (c5 !== 4'd0) $display("FAIL reset_count act=%0d exp=0", c5); else passed++;
    total++; if (out5.valid !== 1'b0) $display("FAIL reset_out_valid act=%b exp=0", out5.valid); else passed++;
    total++; if (out5.data !== 32'd0) $display("FAIL reset_out_data act=%h exp=0", out5.data); else passed++;
    total++; if (in5.ready !== 1'b1) $display("FAIL reset_in_ready act=%b exp=1", in5.ready); else passed++;
    total++; if (ae5 !== 1'b1) $display("FAIL reset_almost_empty act=%b exp=1", ae5); else passed++;
    total++; if (af5 !== 1'b0) $display("FAIL reset_almost_full act=%b exp=0", af5); else passed++;
    total++; if (ov5 !== 1'b0) $display("FAIL reset_overflow act=%b exp=0", ov5); else passed++;
    total++; if (c7 !== 4'd0) $display("FAIL reset_count7 act=%0d exp=0", c7); else passed++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fill_drain();
    out5.ready = 1'b0;
    in5.valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      in5.data = 32'(i);
      tick();
      total++; if (c5 !== 4'(i)) $display("FAIL fill_count i=%0d act=%0d exp=%0d", i, c5, i); else passed++;
      total++; if (af5 !== (i >= 3)) $display("FAIL fill_almost_full i=%0d act=%b exp=%b", i, af5, (i >= 3)); else passed++;
      total++; if (in5.ready !== (i < 5)) $display("FAIL fill_in_ready i=%0d act=%b exp=%b", i, in5.ready, (i < 5)); else passed++;
      total++; if (ov5 !== 1'b0) $display("FAIL fill_overflow i=%0d act=%b exp=0", i, ov5); else passed++;
    end
    in5.data = 32'd6;
    tick();
    total++; if (ov5 !== 1'b1) $display("FAIL full_overflow act=%b exp=1", ov5); else passed++;
    total++; if (c5 !== 4'd5) $display("FAIL full_count act=%0d exp=5", c5); else passed++;
    in5.valid = 1'b0;
    out5.ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      total++; if (out5.valid !== 1'b1) $display("FAIL drain_valid i=%0d act=%b exp=1", i, out5.valid); else passed++;
      total++; if (out5.data !== 32'(i)) $display("FAIL drain_data i=%0d act=%0d exp=%0d", i, out5.data, i); else passed++;
      tick();
    end
    out5.ready = 1'b0;
    total++; if (out5.valid !== 1'b0) $display("FAIL drain_empty act=%b exp=0", out5.valid); else passed++;
    total++; if (out5.data !== 32'd0) $display("FAIL drain_data_zero act=%h exp=0", out5.data); else passed++;
    total++; if (ov5 !== 1'b1) $display("FAIL overflow_sticky act=%b exp=1", ov5); else passed++;
  endtask

  task automatic test_full_pop();
    flush5 = 1'b1;
    tick();
    flush5 = 1'b0;
    total++; if (ov5 !== 1'b0) $display("FAIL flush_clears_ov act=%b exp=0", ov5); else passed++;
    in5.valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in5.data = 32'(10 + i);
      tick();
    end
    in5.data = 32'd99;
    out5.ready = 1'b1;
    tick();
    in5.valid = 1'b0;
    out5.ready = 1'b0;
    total++; if (c5 !== 4'd4) $display("FAIL fullpop_count act=%0d exp=4", c5); else passed++;
    total++; if (in5.ready !== 1'b1) $display("FAIL fullpop_in_ready act=%b exp=1", in5.ready); else passed++;
    total++; if (ov5 !== 1'b1) $display("FAIL fullpop_overflow act=%b exp=1", ov5); else passed++;
    out5.ready = 1'b1;
    for (int i = 11; i <= 14; i++) begin
      total++; if (out5.data !== 32'(i)) $display("FAIL fullpop_data act=%0d exp=%0d", out5.data, i); else passed++;
      tick();
    end
    out5.ready = 1'b0;
    total++; if (out5.valid !== 1'b0) $display("FAIL fullpop_no_99 act=%b exp=0", out5.valid); else passed++;
  endtask

  task automatic test_flush();
    in5.valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in5.data = 32'(20 + i);
      tick();
    end
    total++; if (c5 !== 4'd4) $display("FAIL flush_precount act=%0d exp=4", c5); else passed++;
    flush5 = 1'b1;
    in5.data = 32'd77;
    out5.ready = 1'b1;
    tick();
    flush5 = 1'b0;
    in5.valid = 1'b0;
    out5.ready = 1'b0;
    total++; if (c5 !== 4'd0) $display("FAIL flush_count act=%0d exp=0", c5); else passed++;
    total++; if (out5.valid !== 1'b0) $display("FAIL flush_valid act=%b exp=0", out5.valid); else passed++;
    total++; if (ov5 !== 1'b0) $display("FAIL flush_overflow act=%b exp=0", ov5); else passed++;
    in5.valid = 1'b1;
    in5.data = 32'hA5;
    #1;
    total++; if (out5.valid !== 1'b0) $display("FAIL no_bypass act=%b exp=0", out5.valid); else passed++;
    tick();
    in5.valid = 1'b0;
    total++; if (out5.valid !== 1'b1) $display("FAIL a5_valid act=%b exp=1", out5.valid); else passed++;
    total++; if (out5.data !== 32'hA5) $display("FAIL a5_data act=%h exp=a5", out5.data); else passed++;
    total++; if (c5 !== 4'd1) $display("FAIL a5_count act=%0d exp=1", c5); else passed++;
    out5.ready = 1'b1;
    tick();
    out5.ready = 1'b0;
  endtask

  task automatic test_wrap();
    in5.valid = 1'b1;
    in5.data = 32'd100;
    tick();
    in5.data = 32'd101;
    tick();
    out5.ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in5.data = 32'(102 + i);
      total++; if (out5.data !== 32'(100 + i)) $display("FAIL wrap_data i=%0d act=%0d exp=%0d", i, out5.data, 100 + i); else passed++;
      tick();
      total++; if (c5 !== 4'd2) $display("FAIL wrap_count i=%0d act=%0d exp=2", i, c5); else passed++;
    end
    in5.valid = 1'b0;
    for (int i = 112; i <= 113; i++) begin
      total++; if (out5.data !== 32'(i)) $display("FAIL wrap_tail act=%0d exp=%0d", out5.data, i); else passed++;
      tick();
    end
    out5.ready = 1'b0;
    total++; if (out5.valid !== 1'b0) $display("FAIL wrap_empty act=%b exp=0", out5.valid); else passed++;
  endtask

  task automatic test_random();
    logic [31:0] q[$];
    logic [31:0] exp_data;
    logic        m_ov;
    logic        do_push, do_pop;
    int          n;
    m_ov = 1'b0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      if ((cyc / 500) % 2 == 0) begin
        in7.valid = ($urandom_range(0, 3) != 0);
        out7.ready = ($urandom_range(0, 1) != 0);
      end else begin
        in7.valid = ($urandom_range(0, 1) != 0);
        out7.ready = ($urandom_range(0, 3) != 0);
      end
      in7.data = $urandom;
      #1;
      n = q.size();
      exp_data = (n != 0) ? q[0] : 32'd0;
      total++; if (c7 !== 4'(n)) $display("FAIL rnd_count cyc=%0d act=%0d exp=%0d", cyc, c7, n); else passed++;
      total++; if (in7.ready !== (n != 7)) $display("FAIL rnd_in_ready cyc=%0d act=%b exp=%b", cyc, in7.ready, (n != 7)); else passed++;
      total++; if (out7.valid !== (n != 0)) $display("FAIL rnd_out_valid cyc=%0d act=%b exp=%b", cyc, out7.valid, (n != 0)); else passed++;
      total++; if (out7.data !== exp_data) $display("FAIL rnd_data cyc=%0d act=%h exp=%h", cyc, out7.data, exp_data); else passed++;
      total++; if ({af7, ae7} !== {(n >= 5), (n <= 2)}) $display("FAIL rnd_flags cyc=%0d act=%b%b exp=%b%b", cyc, af7, ae7, (n >= 5), (n <= 2)); else passed++;
      total++; if (ov7 !== m_ov) $display("FAIL rnd_overflow cyc=%0d act=%b exp=%b", cyc, ov7, m_ov); else passed++;
      do_push = in7.valid && (n != 7);
      do_pop  = out7.ready && (n != 0);
      if (in7.valid && n == 7) m_ov = 1'b1;
      @(posedge clk);
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(in7.data);
      #1;
    end
    in7.valid = 1'b0;
    out7.ready = 1'b0;
  endtask

  initial begin
    in5.valid = 1'b0; in5.data = '0; out5.ready = 1'b0;
    in7.valid = 1'b0; in7.data = '0; out7.ready = 1'b0;
    #12 rst = 1'b0;
    tick();
    test_reset();
    test_fill_drain();
    test_full_pop();
    test_flush();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
